// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared FSM states, burst layout and sample unpacking for the sensor frame monitor
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2
    } state_t;

    localparam logic [7:0] BURST_REG = 8'hF7;
    localparam int         BURST_LEN = 8;
    localparam int         IDX_W     = 3;

    localparam int SLOT_PRESS_MSB = 0;
    localparam int SLOT_PRESS_MID = 1;
    localparam int SLOT_PRESS_LSB = 2;
    localparam int SLOT_TEMP_MSB  = 3;
    localparam int SLOT_TEMP_MID  = 4;
    localparam int SLOT_TEMP_LSB  = 5;
    localparam int SLOT_HUM_MSB   = 6;
    localparam int SLOT_HUM_LSB   = 7;

    typedef logic [7:0] burst_t [BURST_LEN];

    typedef struct packed {
        logic [19:0] press;
        logic [19:0] temp;
        logic [15:0] hum;
    } sample_t;

    // The low nibble of each 20-bit XLSB byte is padding and is dropped.
    function automatic sample_t unpack_burst(input burst_t b);
        sample_t s;
        s.press = {b[SLOT_PRESS_MSB], b[SLOT_PRESS_MID], b[SLOT_PRESS_LSB][7:4]};
        s.temp  = {b[SLOT_TEMP_MSB], b[SLOT_TEMP_MID], b[SLOT_TEMP_LSB][7:4]};
        s.hum   = {b[SLOT_HUM_MSB], b[SLOT_HUM_LSB]};
        return s;
    endfunction

endpackage

// File: rtl/sensor_frame_monitor_if.sv
// rtl/sensor_frame_monitor_if.sv - byte stream in, decoded samples and status out
interface sensor_frame_monitor_if;
    logic        frame_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [19:0] press_raw;
    logic [19:0] temp_raw;
    logic [15:0] hum_raw;
    logic        sample_valid;
    logic        frame_err;
    logic        alert;

    modport master (
        output frame_start, byte_valid, byte_data,
        input  press_raw, temp_raw, hum_raw, sample_valid, frame_err, alert
    );

    modport slave (
        input  frame_start, byte_valid, byte_data,
        output press_raw, temp_raw, hum_raw, sample_valid, frame_err, alert
    );
endinterface

// File: rtl/alert_debounce.sv
// rtl/alert_debounce.sv - threshold check with clear hysteresis and N-frame confirmation of alert changes
module alert_debounce #(
    parameter logic [19:0] TEMP_HI   = 20'h86000,
    parameter logic [19:0] TEMP_LO   = 20'h70000,
    parameter logic [15:0] HUM_HI    = 16'hB000,
    parameter logic [19:0] HYST      = 20'h01000,
    parameter int          CONFIRM_N = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic [19:0] temp,
    input  logic [15:0] hum,
    output logic        alert
);
    localparam int          CW          = $clog2(CONFIRM_N + 1);
    localparam logic [19:0] TEMP_HI_CLR = TEMP_HI - HYST;
    localparam logic [19:0] TEMP_LO_CLR = TEMP_LO + HYST;
    localparam logic [15:0] HUM_HI_CLR  = HUM_HI - HYST[15:0];

    logic          bad;
    logic          good;
    logic          oppose;
    logic [CW-1:0] cnt;

    // While alarmed, clearing demands margin inside every threshold.
    always_comb begin
        bad    = (temp > TEMP_HI) || (temp < TEMP_LO) || (hum > HUM_HI);
        good   = alert ? ((temp <= TEMP_HI_CLR) && (temp >= TEMP_LO_CLR) && (hum <= HUM_HI_CLR))
                       : !bad;
        oppose = alert ? good : bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alert <= 1'b0;
            cnt   <= '0;
        end else if (strobe) begin
            if (!oppose) begin
                cnt <= '0;
            end else if (cnt == CW'(CONFIRM_N - 1)) begin
                alert <= ~alert;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sensor_frame_monitor.sv
// rtl/sensor_frame_monitor.sv - collects 0xF7 burst bytes into samples, flags aborted frames, drives health alert
module sensor_frame_monitor
    import sensor_pkg::*;
#(
    parameter logic [19:0] TEMP_HI   = 20'h86000,
    parameter logic [19:0] TEMP_LO   = 20'h70000,
    parameter logic [15:0] HUM_HI    = 16'hB000,
    parameter logic [19:0] HYST      = 20'h01000,
    parameter int          CONFIRM_N = 3,
    parameter int          TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    sensor_frame_monitor_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [TW-1:0]    idle_cnt, idle_next;
    burst_t           shadow;
    burst_t           frame;
    sample_t          sample;
    logic             store, load, err_next;

    logic [19:0] press_q, temp_q;
    logic [15:0] hum_q;
    logic        valid_q, err_q, alert_q;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        idle_next  = idle_cnt;
        store      = 1'b0;
        load       = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_start) begin
                    state_next = COLLECT;
                    idx_next   = '0;
                    idle_next  = '0;
                end
            end
            COLLECT: begin
                if (bus.frame_start) begin
                    err_next  = 1'b1;
                    idx_next  = '0;
                    idle_next = '0;
                end else if (bus.byte_valid) begin
                    store     = 1'b1;
                    idle_next = '0;
                    idx_next  = idx + 1'b1;
                    if (idx == IDX_W'(BURST_LEN - 1)) begin
                        state_next = EVAL;
                        load       = 1'b1;
                    end
                end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                    idx_next   = '0;
                    idle_next  = '0;
                end else begin
                    idle_next = idle_cnt + 1'b1;
                end
            end
            EVAL: begin
                if (bus.frame_start) begin
                    state_next = COLLECT;
                    idx_next   = '0;
                    idle_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Last byte is forwarded straight from the bus so the sample lands with the EVAL cycle.
    always_comb begin
        frame                = shadow;
        frame[BURST_LEN - 1] = bus.byte_data;
        sample               = unpack_burst(frame);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            idle_cnt <= '0;
            for (int i = 0; i < BURST_LEN; i++) shadow[i] <= '0;
            press_q  <= '0;
            temp_q   <= '0;
            hum_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            idle_cnt <= idle_next;
            if (store) shadow[idx] <= bus.byte_data;
            if (load) begin
                press_q <= sample.press;
                temp_q  <= sample.temp;
                hum_q   <= sample.hum;
            end
            valid_q <= load;
            err_q   <= err_next;
        end
    end

    alert_debounce #(
        .TEMP_HI   (TEMP_HI),
        .TEMP_LO   (TEMP_LO),
        .HUM_HI    (HUM_HI),
        .HYST      (HYST),
        .CONFIRM_N (CONFIRM_N)
    ) u_alert_debounce (
        .clk    (clk),
        .rst    (rst),
        .strobe (valid_q),
        .temp   (temp_q),
        .hum    (hum_q),
        .alert  (alert_q)
    );

    assign bus.press_raw    = press_q;
    assign bus.temp_raw     = temp_q;
    assign bus.hum_raw      = hum_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.alert        = alert_q;
endmodule

// File: tb/tb_sensor_frame_monitor.sv
// tb/tb_sensor_frame_monitor.sv - scoreboard bench: directed frames, aborts, timeout, reset and alert debounce
module tb_sensor_frame_monitor;

    typedef logic [7:0] bytes_t [8];

    typedef struct packed {
        logic [19:0] press;
        logic [19:0] temp;
        logic [15:0] hum;
        logic        alert;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sensor_frame_monitor_if bus();

    sensor_frame_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks  = 0;
    int   fails   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every sample_valid pops one expectation; alert is checked one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.sample_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_sample: got press 0x%0h, expected no sample at %0t",
                             bus.press_raw, $time);
                end else begin
                    e = q.pop_front();
                    check("press_raw", 32'(bus.press_raw), 32'(e.press));
                    check("temp_raw",  32'(bus.temp_raw),  32'(e.temp));
                    check("hum_raw",   32'(bus.hum_raw),   32'(e.hum));
                    @(negedge clk);
                    check("alert_after_eval", 32'(bus.alert), 32'(e.alert));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_err) err_seen++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    function automatic bytes_t pack(input logic [19:0] p, input logic [19:0] t, input logic [15:0] h);
        bytes_t b;
        b[0] = p[19:12]; b[1] = p[11:4]; b[2] = {p[3:0], 4'h0};
        b[3] = t[19:12]; b[4] = t[11:4]; b[5] = {t[3:0], 4'h0};
        b[6] = h[15:8];  b[7] = h[7:0];
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input bytes_t b, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(b[i]);
    endtask

    task automatic frame(input logic [19:0] p, input logic [19:0] t, input logic [15:0] h, input logic a);
        q.push_back('{press: p, temp: t, hum: h, alert: a});
        pulse_start();
        send_bytes(pack(p, t, h), 0, 7);
        idle(3);
    endtask

    initial begin
        bytes_t lit;
        bytes_t part;
        bus.frame_start = 1'b0;
        bus.byte_valid  = 1'b0;
        bus.byte_data   = 8'h00;
        #23 rst = 1'b0;
        idle(2);

        check("reset_press", 32'(bus.press_raw), 32'h0);
        check("reset_temp",  32'(bus.temp_raw),  32'h0);
        check("reset_hum",   32'(bus.hum_raw),   32'h0);
        check("reset_alert", 32'(bus.alert),     32'h0);
        check("reset_valid", 32'(bus.sample_valid), 32'h0);
        check("reset_err",   32'(bus.frame_err), 32'h0);

        // Literal burst from the datasheet-style example.
        lit = '{8'h50, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00};
        q.push_back('{press: 20'h50000, temp: 20'h80000, hum: 16'h8000, alert: 1'b0});
        pulse_start();
        send_bytes(lit, 0, 7);
        idle(3);

        // Over-temperature: alert only after the third bad frame.
        frame(20'h12345, 20'h90000, 16'h8000, 1'b0);
        frame(20'h12345, 20'h90000, 16'h8000, 1'b0);
        frame(20'h12345, 20'h90000, 16'h8000, 1'b1);

        // Inside hysteresis band: stays alarmed; well inside: clears on third.
        frame(20'h12345, 20'h85800, 16'h8000, 1'b1);
        frame(20'h12345, 20'h85800, 16'h8000, 1'b1);
        frame(20'h12345, 20'h85800, 16'h8000, 1'b1);
        frame(20'h22222, 20'h80000, 16'h8000, 1'b1);
        frame(20'h22222, 20'h80000, 16'h8000, 1'b1);
        frame(20'h22222, 20'h80000, 16'h8000, 1'b0);

        // Restart mid-frame.
        part = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pulse_start();
        send_bytes(part, 0, 3);
        err_exp++;
        frame(20'h0ABCD, 20'h7F000, 16'h1234, 1'b0);
        check("err_after_restart", 32'(err_seen), 32'(err_exp));

        // Timeout after five bytes, then orphan bytes must be ignored.
        pulse_start();
        send_bytes(part, 0, 4);
        idle(1010);
        err_exp++;
        check("err_after_timeout", 32'(err_seen), 32'(err_exp));
        send_bytes(part, 0, 7);
        idle(3);
        check("hold_press", 32'(bus.press_raw), 32'h0ABCD);
        check("hold_temp",  32'(bus.temp_raw),  32'h7F000);
        check("hold_hum",   32'(bus.hum_raw),   32'h1234);

        // A gap one cycle short of the timeout must not abort.
        q.push_back('{press: 20'h33333, temp: 20'h78000, hum: 16'h2000, alert: 1'b0});
        pulse_start();
        send_bytes(pack(20'h33333, 20'h78000, 16'h2000), 0, 3);
        idle(999);
        send_bytes(pack(20'h33333, 20'h78000, 16'h2000), 4, 7);
        idle(3);
        check("err_no_timeout", 32'(err_seen), 32'(err_exp));

        // Raise alert, then reset in the middle of a frame.
        frame(20'h11111, 20'h90000, 16'h8000, 1'b0);
        frame(20'h11111, 20'h90000, 16'h8000, 1'b0);
        frame(20'h11111, 20'h90000, 16'h8000, 1'b1);
        pulse_start();
        send_bytes(part, 0, 5);
        rst = 1'b1;
        #1;
        check("midrst_press", 32'(bus.press_raw), 32'h0);
        check("midrst_temp",  32'(bus.temp_raw),  32'h0);
        check("midrst_hum",   32'(bus.hum_raw),   32'h0);
        check("midrst_alert", 32'(bus.alert),     32'h0);
        check("midrst_valid", 32'(bus.sample_valid), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(2);
        send_bytes(part, 0, 7);
        idle(3);
        check("orphan_press", 32'(bus.press_raw), 32'h0);

        // Debounce counter was cleared by reset: one bad frame must not alarm.
        frame(20'h44444, 20'h90000, 16'h8000, 1'b0);

        idle(5);
        check("scoreboard_empty", 32'(q.size()), 32'h0);
        check("err_total", 32'(err_seen), 32'(err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
